inverse_kinematics_search: RTL and testbench

//  Inverse of the 3-link planar FK pipeline: given target (X,Y), end orientation phi and link lengths,

---
 rtl/ik_pkg.sv | 31 +++
 rtl/fk_trig_lut.sv | 28 ++
 rtl/inverse_kinematics_search.sv | 256 +++++++++++++++++++++++++
 tb/tb_inverse_kinematics_search.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_pkg.sv
// Shared constants for the planar-arm IK/FK blocks: the discrete joint-angle table,
// its fixed-point cos/sin values, accumulator width and the search FSM encodings.
package ik_pkg;

    localparam int W_ACC  = 48;
    localparam int W_TRIG = 16;
    localparam int SCALE  = 1000;

    localparam int N_ANG    = 9;
    localparam int LAST_IDX = N_ANG - 1;

    localparam int ANG_DEG [N_ANG] = '{0, 30, 45, 60, 90, 120, 135, 150, 180};
    localparam int COS_TBL [N_ANG] = '{1000, 866, 707, 500, 0, -500, -707, -866, -1000};
    localparam int SIN_TBL [N_ANG] = '{0, 500, 707, 866, 1000, 866, 707, 500, 0};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [31:0] ERR_SAT = 32'h7FFF_FFFF;

    // Table index -> angle in degrees; indices past the table read as 0.
    function automatic int ang_of(input logic [3:0] idx);
        ang_of = 0;
        for (int n = 0; n < N_ANG; n++) begin
            if (idx == 4'(n)) ang_of = ANG_DEG[n];
        end
    endfunction

endpackage

// File: rtl/fk_trig_lut.sv
// Combinational angle -> {cos, sin} * SCALE lookup over the joint-angle table.
// hit is low when the angle is not one of the table entries (cos/sin then read 0).
module fk_trig_lut
    import ik_pkg::*;
#(
    parameter int W_ANG = 16
) (
    input  logic signed [W_ANG-1:0]  ang,
    output logic signed [W_TRIG-1:0] cos_val,
    output logic signed [W_TRIG-1:0] sin_val,
    output logic                     hit
);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        cos_val = '0;
        sin_val = '0;
        hit     = 1'b0;
        for (int n = 0; n < N_ANG; n++) begin
            if (int'(ang) == ANG_DEG[n]) begin
                cos_val = W_TRIG'(COS_TBL[n]);
                sin_val = W_TRIG'(SIN_TBL[n]);
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/inverse_kinematics_search.sv
// Exhaustive 3-link planar IK search over the 9x9 (theta1, theta1+theta2) angle grid.
// Optional IK_EARLY_EXIT_EN: stop at the first candidate with zero error.
module inverse_kinematics_search
    import ik_pkg::*;
#(
    parameter int W_ANG = 16,
    parameter int W_LEN = 16,
    parameter int W_POS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_POS-1:0] x_tgt,
    input  logic signed [W_POS-1:0] y_tgt,
    input  logic signed [W_ANG-1:0] phi,
    input  logic signed [W_LEN-1:0] L1,
    input  logic signed [W_LEN-1:0] L2,
    input  logic signed [W_LEN-1:0] L3,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_ANG-1:0] theta1,
    output logic signed [W_ANG-1:0] theta2,
    output logic signed [W_ANG-1:0] theta3,
    output logic [31:0]             err,
    output logic                    exact,
    output logic                    bad_phi
);

    localparam int W_PROD = W_LEN + W_TRIG;
    localparam logic signed [W_ACC-1:0] SCALE_ACC = W_ACC'(SCALE);

`ifdef IK_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic [1:0] state;

    // Job operands captured at acceptance
    logic signed [W_POS-1:0] x_q, y_q;
    logic signed [W_ANG-1:0] phi_q;
    logic signed [W_LEN-1:0] l1_q, l2_q, l3_q;
    logic                    bad_q;

    // Candidate generator and pipeline
    logic [3:0] ci, cj;
    logic       iss_valid;
    logic [3:0] iss_i, iss_j;
    logic       s1_valid;
    logic [3:0] s1_i, s1_j;
    logic signed [W_PROD-1:0] p1x, p1y, p2x, p2y, p3x, p3y;

    logic [W_ACC-1:0] best_err;
    logic [3:0]       best_i, best_j;

    // Trig lookups: a1 and a12 come from the issued indices, phi from the port while
    // idle (to flag bad_phi at acceptance) and from the latched copy during a job.
    logic signed [W_ANG-1:0]  a1, a12, phi_sel;
    logic signed [W_TRIG-1:0] c1, s1, c12, s12, cph, sph;
    logic                     hit1, hit12, phi_hit;

    assign a1      = W_ANG'(ang_of(iss_i));
    assign a12     = W_ANG'(ang_of(iss_j));
    assign phi_sel = (state == ST_IDLE) ? phi : phi_q;

    fk_trig_lut #(.W_ANG(W_ANG)) u_lut_a1 (
        .ang(a1), .cos_val(c1), .sin_val(s1), .hit(hit1)
    );

    fk_trig_lut #(.W_ANG(W_ANG)) u_lut_a12 (
        .ang(a12), .cos_val(c12), .sin_val(s12), .hit(hit12)
    );

    fk_trig_lut #(.W_ANG(W_ANG)) u_lut_phi (
        .ang(phi_sel), .cos_val(cph), .sin_val(sph), .hit(phi_hit)
    );

    // Table angles always hit; only the phi lookup can miss.
    logic unused_hits;
    assign unused_hits = hit1 ^ hit12;

    // Stage 2: position sums and L1 error, all in SCALE units (no division needed)
    logic signed [W_ACC-1:0] sx, sy, tx, ty, dx, dy;
    logic [W_ACC-1:0]        adx, ady, err_c;
    logic                    early_stop;

    always_comb begin
        sx    = W_ACC'(p1x) + W_ACC'(p2x) + W_ACC'(p3x);
        sy    = W_ACC'(p1y) + W_ACC'(p2y) + W_ACC'(p3y);
        tx    = W_ACC'(x_q) * SCALE_ACC;
        ty    = W_ACC'(y_q) * SCALE_ACC;
        dx    = tx - sx;
        dy    = ty - sy;
        adx   = dx[W_ACC-1] ? W_ACC'(-dx) : W_ACC'(dx);
        ady   = dy[W_ACC-1] ? W_ACC'(-dy) : W_ACC'(dy);
        err_c = adx + ady;
    end

    assign early_stop = EARLY_EXIT && s1_valid && (err_c == '0);

    // Result values presented when the job completes
    logic signed [W_ANG-1:0] pub_t1, pub_t2, pub_t3;
    logic [31:0]             pub_err;
    logic                    pub_exact;

    always_comb begin
        pub_t1    = '0;
        pub_t2    = '0;
        pub_t3    = '0;
        pub_err   = ERR_SAT;
        pub_exact = 1'b0;
        if (!bad_q) begin
            pub_t1    = W_ANG'(ang_of(best_i));
            pub_t2    = W_ANG'(ang_of(best_j) - ang_of(best_i));
            pub_t3    = phi_q - W_ANG'(ang_of(best_j));
            pub_err   = (best_err > W_ACC'(ERR_SAT)) ? ERR_SAT : best_err[31:0];
            pub_exact = (best_err == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the
    // block deliberately override earlier defaults (e.g. the early-exit squash).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            theta1    <= '0;
            theta2    <= '0;
            theta3    <= '0;
            err       <= '0;
            exact     <= 1'b0;
            bad_phi   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            phi_q     <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            l3_q      <= '0;
            bad_q     <= 1'b0;
            ci        <= '0;
            cj        <= '0;
            iss_valid <= 1'b0;
            iss_i     <= '0;
            iss_j     <= '0;
            s1_valid  <= 1'b0;
            s1_i      <= '0;
            s1_j      <= '0;
            p1x       <= '0;
            p1y       <= '0;
            p2x       <= '0;
            p2y       <= '0;
            p3x       <= '0;
            p3y       <= '0;
            best_err  <= '0;
            best_i    <= '0;
            best_j    <= '0;
        end else begin
            iss_valid <= 1'b0;
            s1_valid  <= iss_valid;

            if (iss_valid) begin
                s1_i <= iss_i;
                s1_j <= iss_j;
                p1x  <= W_PROD'(l1_q) * W_PROD'(c1);
                p1y  <= W_PROD'(l1_q) * W_PROD'(s1);
                p2x  <= W_PROD'(l2_q) * W_PROD'(c12);
                p2y  <= W_PROD'(l2_q) * W_PROD'(s12);
                p3x  <= W_PROD'(l3_q) * W_PROD'(cph);
                p3y  <= W_PROD'(l3_q) * W_PROD'(sph);
            end

            // Strict less-than keeps the lowest candidate index on ties
            if (s1_valid && (err_c < best_err)) begin
                best_err <= err_c;
                best_i   <= s1_i;
                best_j   <= s1_j;
            end

            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        x_q      <= x_tgt;
                        y_q      <= y_tgt;
                        phi_q    <= phi;
                        l1_q     <= L1;
                        l2_q     <= L2;
                        l3_q     <= L3;
                        best_err <= '1;
                        best_i   <= '0;
                        best_j   <= '0;
                        ci       <= '0;
                        cj       <= '0;
                        bad_q    <= !phi_hit;
                        state    <= phi_hit ? ST_SEARCH : ST_DONE;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                ST_SEARCH: begin
                    iss_valid <= 1'b1;
                    iss_i     <= ci;
                    iss_j     <= cj;
                    if (cj == 4'(LAST_IDX)) begin
                        cj <= '0;
                        ci <= ci + 4'd1;
                    end else begin
                        cj <= cj + 4'd1;
                    end
                    if (ci == 4'(LAST_IDX) && cj == 4'(LAST_IDX)) state <= ST_FLUSH;
                end

                ST_FLUSH: begin
                    if (!iss_valid && !s1_valid) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        theta1    <= pub_t1;
                        theta2    <= pub_t2;
                        theta3    <= pub_t3;
                        err       <= pub_err;
                        exact     <= pub_exact;
                        bad_phi   <= bad_q;
                    end
                end

                default: begin
                    // Bad-phi jobs arrive here with out_valid low and publish one edge later
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        theta1    <= pub_t1;
                        theta2    <= pub_t2;
                        theta3    <= pub_t3;
                        err       <= pub_err;
                        exact     <= pub_exact;
                        bad_phi   <= bad_q;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
            endcase

            if (early_stop) begin
                iss_valid <= 1'b0;
                s1_valid  <= 1'b0;
                state     <= ST_FLUSH;
            end
        end
    end

endmodule

// File: tb/tb_inverse_kinematics_search.sv
// Directed-vector bench for inverse_kinematics_search; expected values are hand-derived
// from the angle table. Honours IK_EARLY_EXIT_EN for the exact-hit latency.
module tb_inverse_kinematics_search;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] x_tgt = '0;
    logic signed [31:0] y_tgt = '0;
    logic signed [15:0] phi = '0;
    logic signed [15:0] L1 = '0;
    logic signed [15:0] L2 = '0;
    logic signed [15:0] L3 = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] theta1, theta2, theta3;
    logic [31:0]        err;
    logic               exact;
    logic               bad_phi;

    int n_vec = 0;
    int n_bad = 0;

`ifdef IK_EARLY_EXIT_EN
    localparam int LAT_EXACT = 4;
`else
    localparam int LAT_EXACT = 84;
`endif

    always #5 clk = ~clk;

    inverse_kinematics_search dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_tgt(x_tgt), .y_tgt(y_tgt), .phi(phi), .L1(L1), .L2(L2), .L3(L3),
        .out_valid(out_valid), .out_ready(out_ready),
        .theta1(theta1), .theta2(theta2), .theta3(theta3),
        .err(err), .exact(exact), .bad_phi(bad_phi)
    );

    // Submit one job, scramble the inputs after acceptance, and return the number of
    // edges from the acceptance edge to out_valid (-1 on timeout).
    task automatic run_job(input int x, input int y, input int ph, input int l1,
                           input int l2, input int l3, output int lat);
        bit got;
        @(negedge clk);
        x_tgt = x; y_tgt = y; phi = 16'(ph);
        L1 = 16'(l1); L2 = 16'(l2); L3 = 16'(l3);
        in_valid = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        lat = -1;
        if (!got) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_tgt = 12345; y_tgt = -777; phi = 16'sd45;
        L1 = 16'sd7; L2 = 16'sd3; L3 = 16'sd11;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL handshake: out_valid,in_ready=%b, required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_vec++;
        if ({in_ready, out_valid, theta1, theta2, theta3, err, exact, bad_phi} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b t=%0d/%0d/%0d err=%0d, required all 0",
                     in_ready, out_valid, theta1, theta2, theta3, err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_edge: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_exact();
        int lat;
        run_job(300, 0, 0, 100, 100, 100, lat);
        n_vec++;
        if (lat !== LAT_EXACT) begin
            n_bad++;
            $display("FAIL exact_latency: got %0d, required %0d", lat, LAT_EXACT);
        end
        n_vec++;
        if ({theta1, theta2, theta3, err, exact, bad_phi} !== {16'sd0, 16'sd0, 16'sd0, 32'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL exact_result: t=%0d/%0d/%0d err=%0d exact=%b bad=%b, required 0/0/0 err=0 exact=1 bad=0",
                     theta1, theta2, theta3, err, exact, bad_phi);
        end
        do_handshake();
    endtask

    task automatic test_reachable();
        int lat;
        run_job(86, 250, 90, 100, 100, 100, lat);
        n_vec++;
        if (lat !== 84) begin
            n_bad++;
            $display("FAIL reach_latency: got %0d, required 84", lat);
        end
        n_vec++;
        if ({theta1, theta2, theta3, err, exact, bad_phi} !== {16'sd30, 16'sd60, 16'sd0, 32'd600, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reach_result: t=%0d/%0d/%0d err=%0d exact=%b, required 30/60/0 err=600 exact=0",
                     theta1, theta2, theta3, err, exact);
        end
        do_handshake();
    endtask

    task automatic test_unreachable();
        int lat;
        run_job(1000, 0, 0, 100, 100, 100, lat);
        n_vec++;
        if (lat !== 84) begin
            n_bad++;
            $display("FAIL unreach_latency: got %0d, required 84", lat);
        end
        n_vec++;
        if ({theta1, theta2, theta3, err, exact} !== {16'sd0, 16'sd0, 16'sd0, 32'd700000, 1'b0}) begin
            n_bad++;
            $display("FAIL unreach_result: t=%0d/%0d/%0d err=%0d exact=%b, required 0/0/0 err=700000 exact=0",
                     theta1, theta2, theta3, err, exact);
        end
        do_handshake();
    endtask

    task automatic test_bad_phi();
        int lat;
        run_job(300, 0, 10, 100, 100, 100, lat);
        n_vec++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL badphi_latency: got %0d, required 1", lat);
        end
        n_vec++;
        if ({theta1, theta2, theta3, err, exact, bad_phi} !== {16'sd0, 16'sd0, 16'sd0, 32'h7FFF_FFFF, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL badphi_result: t=%0d/%0d/%0d err=%0h exact=%b bad=%b, required 0/0/0 err=7fffffff exact=0 bad=1",
                     theta1, theta2, theta3, err, exact, bad_phi);
        end
        do_handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        run_job(300, 0, 0, 100, 100, 100, lat);
        n_vec++;
        if (lat !== LAT_EXACT) begin
            n_bad++;
            $display("FAIL bp_latency: got %0d, required %0d", lat, LAT_EXACT);
        end
        @(negedge clk);
        in_valid = 1'b1;
        x_tgt = 86; y_tgt = 250; phi = 16'sd90;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({out_valid, in_ready, theta1, theta2, theta3, err, exact} !==
                {1'b1, 1'b0, 16'sd0, 16'sd0, 16'sd0, 32'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: v=%b rdy=%b t=%0d/%0d/%0d err=%0d, required v=1 rdy=0 0/0/0 err=0",
                         c, out_valid, in_ready, theta1, theta2, theta3, err);
            end
        end
        in_valid = 1'b0;
        do_handshake();
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen;
        @(negedge clk);
        x_tgt = 86; y_tgt = 250; phi = 16'sd90;
        L1 = 16'sd100; L2 = 16'sd100; L3 = 16'sd100;
        in_valid = 1'b1;
        for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 41; c++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, in_ready, theta1, theta2, theta3, err, exact, bad_phi} !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: v=%b rdy=%b t=%0d/%0d/%0d err=%0d, required all 0",
                     out_valid, in_ready, theta1, theta2, theta3, err);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_valid: out_valid seen %0d cycles, required 0", seen);
        end
        run_job(86, 250, 90, 100, 100, 100, lat);
        n_vec++;
        if (lat !== 84 || {theta1, theta2, theta3, err, exact} !== {16'sd30, 16'sd60, 16'sd0, 32'd600, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_rerun: lat=%0d t=%0d/%0d/%0d err=%0d, required lat=84 30/60/0 err=600",
                     lat, theta1, theta2, theta3, err);
        end
        do_handshake();
    endtask

    initial begin
        test_reset();
        test_exact();
        test_reachable();
        test_unreachable();
        test_bad_phi();
        test_backpressure();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
